// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-memory wait freezes, a memory watchdog and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             dbg_state
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // The first wait cycle is spent in RUN, so the counter trips two below the limit.
  localparam logic [7:0] WAIT_TRIP = 8'(MEM_TIMEOUT - 2);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             mem_hold;
  logic             load_use;

  assign mem_hold = mem_req & ~dmem_ready;
  assign load_use = ex_memread & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_hold) state_d = MEM_WAIT;
      MEM_WAIT: if (!mem_req || dmem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Controls are forced low while reset is held so downstream registers see no stray holds.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    if (rstn) begin
      if (mem_hold) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (ex_redirect) begin
        pc_redirect = 1'b1;
        pc_target   = ex_target;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MEM_WAIT && state_d == MEM_WAIT) begin
        if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_q <= 8'd0;
      end
      if (state_q == MEM_WAIT && mem_hold && wait_cnt_q == WAIT_TRIP) err_q <= 1'b1;
      if (pc_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (pc_redirect && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout_err = err_q;
  assign stall_count     = stall_cnt_q;
  assign flush_count     = flush_cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TB_CNT_W   = 4;
  localparam int TB_TIMEOUT = 4;
  localparam int SAT        = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                rstn;
  logic [4:0]          id_rs1, id_rs2, ex_rd;
  logic                id_uses_rs1, id_uses_rs2, ex_memread, ex_redirect;
  logic [31:0]         ex_target;
  logic                mem_req, dmem_ready;
  logic                pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic                exmem_stall, memwb_flush, pc_redirect, mem_timeout_err, dbg_state;
  logic [31:0]         pc_target;
  logic [TB_CNT_W-1:0] stall_count, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_stall, m_flush, m_run;
  bit m_err, m_wait;
  bit e_hold, e_pc_stall, e_ifid_stall, e_ifid_flush, e_idex_stall, e_idex_flush;
  bit e_exmem_stall, e_memwb_flush, e_pc_redirect;
  logic [31:0] e_pc_target;

  pipeline_hazard_ctrl #(.CNT_W(TB_CNT_W), .MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .mem_timeout_err(mem_timeout_err), .stall_count(stall_count), .flush_count(flush_count),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0; ex_redirect = 1'b0; ex_target = 32'd0;
    mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic model_clear();
    m_stall = 0; m_flush = 0; m_run = 0; m_err = 1'b0; m_wait = 1'b0;
  endtask

  // Expected controls straight from the hazard priority rules.
  task automatic model_eval();
    bit lu;
    lu = ex_memread && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e_hold = mem_req && !dmem_ready;
    {e_pc_stall, e_ifid_stall, e_ifid_flush, e_idex_stall, e_idex_flush} = '0;
    {e_exmem_stall, e_memwb_flush, e_pc_redirect} = '0;
    e_pc_target = 32'd0;
    if (rstn) begin
      if (e_hold) begin
        {e_pc_stall, e_ifid_stall, e_idex_stall, e_exmem_stall, e_memwb_flush} = 5'b11111;
      end else if (ex_redirect) begin
        e_pc_redirect = 1'b1; e_pc_target = ex_target;
        e_ifid_flush = 1'b1; e_idex_flush = 1'b1;
      end else if (lu) begin
        e_pc_stall = 1'b1; e_ifid_stall = 1'b1; e_idex_flush = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    if (e_pc_stall && m_stall < SAT) m_stall++;
    if (e_pc_redirect && m_flush < SAT) m_flush++;
    m_run = e_hold ? m_run + 1 : 0;
    if (m_run >= TB_TIMEOUT) m_err = 1'b1;
    m_wait = e_hold;
  endtask

  task automatic check_all(input string tag);
    model_eval();
    chk({tag, ".pc_stall"},    32'(pc_stall),    32'(e_pc_stall));
    chk({tag, ".ifid_stall"},  32'(ifid_stall),  32'(e_ifid_stall));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_ifid_flush));
    chk({tag, ".idex_stall"},  32'(idex_stall),  32'(e_idex_stall));
    chk({tag, ".idex_flush"},  32'(idex_flush),  32'(e_idex_flush));
    chk({tag, ".exmem_stall"}, 32'(exmem_stall), 32'(e_exmem_stall));
    chk({tag, ".memwb_flush"}, 32'(memwb_flush), 32'(e_memwb_flush));
    chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(e_pc_redirect));
    chk({tag, ".pc_target"},   pc_target,        e_pc_target);
    chk({tag, ".timeout_err"}, 32'(mem_timeout_err), 32'(m_err));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
    chk({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush));
    chk({tag, ".state"},       32'(dbg_state),   32'(m_wait));
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (rstn) model_update();
    #1;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    model_clear();
    check_all({tag, ".now"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_clear();
    #2;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    step("idle");

    // load-use on rs1: one bubble only
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    chk("lu.pc_stall", 32'(pc_stall), 32'd1);
    chk("lu.idex_flush", 32'(idex_flush), 32'd1);
    step("lu");
    idle_inputs();
    step("lu_after");
    chk("lu.stall_count", 32'(stall_count), 32'd1);

    // x0 destination never hazards
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    chk("x0.pc_stall", 32'(pc_stall), 32'd0);
    step("x0");
    idle_inputs();

    // redirect, then redirect with a simultaneous load-use
    ex_redirect = 1'b1; ex_target = 32'h0000_0100;
    #1;
    chk("redir.pc_target", pc_target, 32'h100);
    step("redir");
    chk("redir.flush_count", 32'(flush_count), 32'd1);
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #1;
    chk("redir_lu.pc_stall", 32'(pc_stall), 32'd0);
    chk("redir_lu.pc_redirect", 32'(pc_redirect), 32'd1);
    step("redir_lu");
    chk("redir_lu.flush_count", 32'(flush_count), 32'd2);
    idle_inputs();

    // three-cycle memory wait with a redirect parked in EX
    mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw.pc_redirect_held", 32'(pc_redirect), 32'd0);
      step("mw");
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw.redirect_on_ready", 32'(pc_redirect), 32'd1);
    step("mw_ready");
    idle_inputs();
    step("mw_after");
    chk("mw.state_run", 32'(dbg_state), 32'd0);
    chk("mw.stall_count", 32'(stall_count), 32'd4);
    chk("mw.no_timeout", 32'(mem_timeout_err), 32'd0);

    // watchdog trips after the fourth consecutive wait cycle, then sticks
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("wd");
    chk("wd.not_yet", 32'(mem_timeout_err), 32'd0);
    step("wd4");
    chk("wd.tripped", 32'(mem_timeout_err), 32'd1);
    dmem_ready = 1'b1;
    step("wd_ready");
    chk("wd.sticky", 32'(mem_timeout_err), 32'd1);

    // reset in the middle of a wait
    dmem_ready = 1'b0;
    step("rw1");
    step("rw2");
    async_reset("rst_mid_wait");
    chk("rst.err_clear", 32'(mem_timeout_err), 32'd0);
    chk("rst.stall_zero", 32'(stall_count), 32'd0);
    idle_inputs();
    step("post_rst");

    // stall counter saturation
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.stall_count", 32'(stall_count), 32'd15);
    idle_inputs();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      id_rs1      = 5'($urandom_range(3, 0));
      id_rs2      = 5'($urandom_range(3, 0));
      ex_rd       = 5'($urandom_range(3, 0));
      id_uses_rs1 = 1'($urandom_range(1, 0));
      id_uses_rs2 = 1'($urandom_range(1, 0));
      ex_memread  = 1'($urandom_range(1, 0));
      ex_redirect = ($urandom_range(3, 0) == 0);
      ex_target   = $urandom;
      mem_req     = ($urandom_range(9, 0) < 5);
      dmem_ready  = ($urandom_range(9, 0) < 4);
      if ($urandom_range(119, 0) == 0) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Drives the stall (hold) and flush (bubble) controls of the PC and of the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard classes:
  - load-use data hazards;
  - EX-resolved branch/jump redirects;
  - multi-cycle data-memory waits.
- Also keeps a memory-timeout watchdog and saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of stall_count and flush_count
MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles before mem_timeout_err is set (legal range 2..255)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset; asynchronous, active-low
id_rs1  input  5  rs1 of the instruction in ID
id_rs2  input  5  rs2 of the instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  destination register of the instruction in EX
ex_memread  input  1  EX instruction is a load
ex_redirect  input  1  EX has a taken branch, JAL or JALR
ex_target  input  32  redirect target address
mem_req  input  1  MEM instruction accesses data memory
dmem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold PC
ifid_stall  output  1  hold IF/ID
ifid_flush  output  1  zero IF/ID
idex_stall  output  1  hold ID/EX
idex_flush  output  1  zero ID/EX
exmem_stall  output  1  hold EX/MEM
memwb_flush  output  1  zero MEM/WB (bubble into WB)
pc_redirect  output  1  load PC from pc_target
pc_target  output  32  redirect address
mem_timeout_err  output  1  sticky watchdog error
stall_count  output  CNT_W  saturating count of cycles with pc_stall=1
flush_count  output  CNT_W  saturating count of redirects taken

Behaviour:
- The single clock is clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - FSM = RUN;
  - wait counter = 0;
  - mem_timeout_err = 0;
  - stall_count = 0, flush_count = 0.
  - All control outputs evaluate to 0 while rstn=0.
- Control outputs are combinational from the inputs and the registered state, with zero latency. The FSM and counters update on the rising edge of clk.
- FSM states: RUN and MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req=1 and dmem_ready=0.
  - MEM_WAIT -> RUN on the cycle dmem_ready=1.
  - MEM_WAIT -> RUN if mem_req drops (abandoned access).
- Hazard terms:
  - mem_hold = mem_req & ~dmem_ready, valid in either state.
  - load_use = ex_memread & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority, highest first:
  1. mem_hold:
     - pc_stall = ifid_stall = idex_stall = exmem_stall = 1;
     - memwb_flush = 1;
     - every other output = 0.
     - Redirect and load-use are suppressed. EX is frozen, so their inputs stay stable and are re-evaluated after the hold.
  2. ex_redirect:
     - pc_redirect = 1, pc_target = ex_target;
     - ifid_flush = 1, idex_flush = 1.
     - load_use is ignored because the ID instruction is squashed.
  3. load_use:
     - pc_stall = 1, ifid_stall = 1, idex_flush = 1;
     - exactly one bubble per hazard. Next cycle the load has left EX, so load_use clears naturally.
  4. Otherwise all controls are 0.
- pc_target = ex_target when pc_redirect=1, otherwise 0.
- Stall and flush are never both 1 on the same register in the same cycle.
- Watchdog:
  - The wait counter increments each cycle in MEM_WAIT and clears on leaving MEM_WAIT.
  - When it reaches MEM_TIMEOUT-1 while still waiting, mem_timeout_err is set.
  - mem_timeout_err is cleared only by reset.
  - The pipeline keeps stalling; the error is report-only.
- Counters:
  - stall_count increments on every cycle with pc_stall=1.
  - flush_count increments on every cycle with pc_redirect=1.
  - Both saturate at all-ones with no wrap-around.
- Reset asserted mid-stall: all state and outputs clear immediately (asynchronously). Operation resumes in RUN after rstn rises.
- x0 is never a hazard source: ex_rd=0 never raises load_use.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only; stall_count=1.
- x0 case: ex_memread=1, ex_rd=0, id_rs2=0, id_uses_rs2=1 -> all controls 0.
- Redirect: ex_redirect=1, ex_target=0x0000_0100 -> pc_redirect=1, pc_target=0x100, ifid_flush=idex_flush=1; flush_count=1. Repeat with load_use also true -> identical outputs, no pc_stall.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then ready -> 3 cycles of full freeze plus memwb_flush; FSM returns to RUN; stall_count=3. Hold ex_redirect=1 throughout -> pc_redirect=0 during the wait, 1 on the ready cycle.
- Watchdog: MEM_TIMEOUT=4, hold mem_req=1, dmem_ready=0 -> mem_timeout_err rises after the 4th wait cycle and stays 1 after dmem_ready; reset clears it.
- Saturation/reset: CNT_W=4, 20 load-use cycles -> stall_count=15. Assert rstn=0 mid-wait -> outputs 0 immediately, counters 0.
